ant_pwr_rbg_acc: RTL and testbench

Upstream stage of the CPRI TX data path. It takes 16-antenna frequency-domain REs and computes the per-antenna power (I²+Q²) accumulated over each RBG. It forwards the REs latency-aligned with the power results. Its outputs drive the rx_vld/sop/eop, rbg_load, ant_data, ant_pwr and rbg_idx inputs of the CPRI TX top.

---
 rtl/ant_pwr_rbg_acc.sv | 252 +++++++++++++++++++++++++
 tb/tb_ant_pwr_rbg_acc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_pwr_rbg_acc.sv
// ant_pwr_rbg_acc: 16-antenna RE power accumulated per RBG, REs forwarded with matched latency.
// Optional macro PWR_SAT_CNT_EN adds o_sat_cnt (sticky count of saturated antenna results).
module ant_pwr_rbg_acc #(
  parameter int RBG_PRB   = 4,
  parameter int ACC_W     = 40,
  parameter int PWR_SHIFT = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_vld,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic [15:0][31:0] i_ant_data,
  output logic              o_vld,
  output logic              o_sop,
  output logic              o_eop,
  output logic [15:0][31:0] o_ant_data,
  output logic              o_rbg_load,
  output logic [15:0][31:0] o_ant_pwr,
  output logic [3:0]        o_rbg_idx
`ifdef PWR_SAT_CNT_EN
  ,
  output logic [15:0]       o_sat_cnt
`endif
);

  localparam logic [7:0] RE_LAST = 8'(RBG_PRB * 12 - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  function automatic logic [31:0] sat_pwr(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] sh;
    sh = acc >> PWR_SHIFT;
    if (|sh[ACC_W-1:32]) begin
      sat_pwr = 32'hFFFF_FFFF;
    end else begin
      sat_pwr = sh[31:0];
    end
  endfunction

`ifdef PWR_SAT_CNT_EN
  function automatic logic is_sat(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] sh;
    sh = acc >> PWR_SHIFT;
    is_sat = |sh[ACC_W-1:32];
  endfunction
`endif

  state_t            state_q, state_d;
  logic [7:0]        re_cnt_q, re_cnt_d;
  logic [3:0]        rbg_cnt_q, rbg_cnt_d;
  logic [7:0]        cur_idx_s;
  logic [3:0]        cur_rbg_s;
  logic              acc_en_s, first_s, close_s;

  logic [2:0]              vld_q, sop_q, eop_q;
  logic [2:0][15:0][31:0]  data_q;
  logic [1:0]              acc_en_q, first_q;
  logic [2:0]              close_q;
  logic [2:0][3:0]         idx_q;

  logic signed [31:0] ext_i_s [16];
  logic signed [31:0] ext_q_s [16];
  logic [31:0]        ii_s [16];
  logic [31:0]        qq_s [16];
  logic [31:0]        ii_q [16];
  logic [31:0]        qq_q [16];
  logic [31:0]        sum_q [16];
  logic [ACC_W-1:0]   acc_q [16];
  logic [31:0]        pwr_sat_s [16];

  // RBG framing decisions made on the incoming RE.
  always_comb begin
    state_d   = state_q;
    re_cnt_d  = re_cnt_q;
    rbg_cnt_d = rbg_cnt_q;
    acc_en_s  = 1'b0;
    first_s   = 1'b0;
    close_s   = 1'b0;
    cur_idx_s = re_cnt_q;
    cur_rbg_s = rbg_cnt_q;
    if (i_sop) begin
      cur_idx_s = 8'd0;
      cur_rbg_s = 4'd0;
    end else begin
      cur_idx_s = re_cnt_q;
      cur_rbg_s = rbg_cnt_q;
    end
    if (i_vld) begin
      case (state_q)
        ST_IDLE: acc_en_s = i_sop;
        ST_ACC:  acc_en_s = 1'b1;
        default: acc_en_s = 1'b0;
      endcase
    end else begin
      acc_en_s = 1'b0;
    end
    if (acc_en_s) begin
      first_s = (cur_idx_s == 8'd0);
      close_s = i_eop | (cur_idx_s == RE_LAST);
      state_d = i_eop ? ST_IDLE : ST_ACC;
      if (close_s) begin
        re_cnt_d  = 8'd0;
        rbg_cnt_d = cur_rbg_s + 4'd1;
      end else begin
        re_cnt_d  = cur_idx_s + 8'd1;
        rbg_cnt_d = cur_rbg_s;
      end
    end else begin
      state_d   = state_q;
      re_cnt_d  = re_cnt_q;
      rbg_cnt_d = rbg_cnt_q;
    end
  end

  // Framing state registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      re_cnt_q  <= 8'd0;
      rbg_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      re_cnt_q  <= re_cnt_d;
      rbg_cnt_q <= rbg_cnt_d;
    end
  end

  // Squares of I and Q per antenna; result is non-negative and below 2^31.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      ext_i_s[k] = {{16{i_ant_data[k][31]}}, i_ant_data[k][31:16]};
      ext_q_s[k] = {{16{i_ant_data[k][15]}}, i_ant_data[k][15:0]};
      ii_s[k]    = ext_i_s[k] * ext_i_s[k];
      qq_s[k]    = ext_q_s[k] * ext_q_s[k];
    end
  end

  // Delay lines for forwarded REs and the framing controls.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q    <= 3'd0;
      sop_q    <= 3'd0;
      eop_q    <= 3'd0;
      data_q   <= '0;
      acc_en_q <= 2'd0;
      first_q  <= 2'd0;
      close_q  <= 3'd0;
      idx_q    <= '0;
    end else begin
      vld_q    <= {vld_q[1:0], i_vld};
      sop_q    <= {sop_q[1:0], i_sop};
      eop_q    <= {eop_q[1:0], i_eop};
      data_q   <= {data_q[1:0], i_ant_data};
      acc_en_q <= {acc_en_q[0], acc_en_s};
      first_q  <= {first_q[0], first_s};
      close_q  <= {close_q[1:0], close_s};
      idx_q    <= {idx_q[1:0], cur_rbg_s};
    end
  end

  // Square, sum and accumulate stages.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < 16; k++) begin
        ii_q[k]  <= 32'd0;
        qq_q[k]  <= 32'd0;
        sum_q[k] <= 32'd0;
        acc_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        ii_q[k]  <= ii_s[k];
        qq_q[k]  <= qq_s[k];
        sum_q[k] <= ii_q[k] + qq_q[k];
        if (acc_en_q[1]) begin
          if (first_q[1]) begin
            acc_q[k] <= {{(ACC_W-32){1'b0}}, sum_q[k]};
          end else begin
            acc_q[k] <= acc_q[k] + {{(ACC_W-32){1'b0}}, sum_q[k]};
          end
        end else begin
          acc_q[k] <= acc_q[k];
        end
      end
    end
  end

  // Scale and saturate the closed accumulators to 32 bits.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      pwr_sat_s[k] = sat_pwr(acc_q[k]);
    end
  end

  // Output registers: forwarded RE and the RBG power result.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_vld      <= 1'b0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      o_ant_data <= '0;
      o_rbg_load <= 1'b0;
      o_ant_pwr  <= '0;
      o_rbg_idx  <= 4'd0;
    end else begin
      o_vld      <= vld_q[2];
      o_sop      <= sop_q[2];
      o_eop      <= eop_q[2];
      o_ant_data <= data_q[2];
      o_rbg_load <= close_q[2];
      if (close_q[2]) begin
        o_rbg_idx <= idx_q[2];
        for (int k = 0; k < 16; k++) begin
          o_ant_pwr[k] <= pwr_sat_s[k];
        end
      end else begin
        o_rbg_idx <= o_rbg_idx;
        o_ant_pwr <= o_ant_pwr;
      end
    end
  end

`ifdef PWR_SAT_CNT_EN
  logic [4:0]  sat_num_s;
  logic [16:0] sat_sum_s;

  // Count of antennas saturating in the RBG being closed.
  always_comb begin
    sat_num_s = 5'd0;
    for (int k = 0; k < 16; k++) begin
      sat_num_s = sat_num_s + {4'd0, is_sat(acc_q[k])};
    end
    sat_sum_s = {1'b0, o_sat_cnt} + {12'd0, sat_num_s};
  end

  // Sticky saturation counter, capped at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_sat_cnt <= 16'd0;
    end else if (close_q[2]) begin
      o_sat_cnt <= sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
    end else begin
      o_sat_cnt <= o_sat_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_ant_pwr_rbg_acc.sv
// Self-checking bench for ant_pwr_rbg_acc: directed cases plus randomized packets
// checked every cycle against a packet-level power model.
module tb_ant_pwr_rbg_acc;

  localparam int RBG_PRB   = 4;
  localparam int ACC_W     = 40;
  localparam int PWR_SHIFT = 0;
  localparam int RBG_RE    = RBG_PRB * 12;
  localparam int NCYC      = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_reset, i_vld, i_sop, i_eop;
  logic [15:0][31:0] i_ant_data;
  logic              o_vld, o_sop, o_eop, o_rbg_load;
  logic [15:0][31:0] o_ant_data, o_ant_pwr;
  logic [3:0]        o_rbg_idx;
`ifdef PWR_SAT_CNT_EN
  logic [15:0]       o_sat_cnt;
`endif

  ant_pwr_rbg_acc #(.RBG_PRB(RBG_PRB), .ACC_W(ACC_W), .PWR_SHIFT(PWR_SHIFT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop),
    .i_ant_data(i_ant_data), .o_vld(o_vld), .o_sop(o_sop), .o_eop(o_eop),
    .o_ant_data(o_ant_data), .o_rbg_load(o_rbg_load), .o_ant_pwr(o_ant_pwr),
    .o_rbg_idx(o_rbg_idx)
`ifdef PWR_SAT_CNT_EN
    , .o_sat_cnt(o_sat_cnt)
`endif
  );

  typedef struct {
    logic              rst, vld, sop, eop, load;
    logic [15:0][31:0] data;
    logic [15:0][31:0] pwr;
    logic [3:0]        idx;
    logic [15:0]       sat;
  } exp_t;

  exp_t   exp_q [NCYC];
  int     pe_cnt    = 0;
  int     checks    = 0;
  int     errors    = 0;
  int     load_seen = 0;

  // Packet-level model state
  bit     m_in_pkt;
  int     m_cnt, m_rbg, m_sat;
  longint m_acc [16];

  function automatic exp_t zero_exp();
    exp_t e;
    e.rst = 1'b0; e.vld = 1'b0; e.sop = 1'b0; e.eop = 1'b0; e.load = 1'b0;
    e.data = '0; e.pwr = '0; e.idx = 4'd0; e.sat = 16'd0;
    return e;
  endfunction

  function automatic longint re_pwr(input logic [31:0] w);
    longint iv, qv;
    iv = longint'($signed(w[31:16]));
    qv = longint'($signed(w[15:0]));
    return iv * iv + qv * qv;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors < 20) $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, expv);
    end
  endtask

  task automatic model_apply(input int n, input logic rst, vld, sop, eop,
                             input logic [15:0][31:0] d);
    exp_t e;
    logic [63:0] sh;
    int ns;
    if (n + 3 >= NCYC) begin
      $display("FAIL cycle_budget actual=%0d required<%0d", n + 3, NCYC);
      $fatal(1);
    end
    if (rst) begin
      for (int j = 0; j < 4; j++) exp_q[n + j] = zero_exp();
      exp_q[n].rst = 1'b1;
      m_in_pkt = 1'b0; m_cnt = 0; m_rbg = 0; m_sat = 0;
      for (int k = 0; k < 16; k++) m_acc[k] = 0;
      return;
    end
    e = zero_exp();
    e.vld = vld; e.sop = sop; e.eop = eop; e.data = d;
    if (vld) begin
      if (sop) begin
        m_in_pkt = 1'b1; m_cnt = 0; m_rbg = 0;
        for (int k = 0; k < 16; k++) m_acc[k] = 0;
      end
      if (m_in_pkt) begin
        for (int k = 0; k < 16; k++) m_acc[k] += re_pwr(d[k]);
        m_cnt++;
        if (m_cnt == RBG_RE || eop) begin
          ns = 0;
          e.load = 1'b1;
          e.idx  = 4'(m_rbg);
          for (int k = 0; k < 16; k++) begin
            sh = 64'(m_acc[k] >>> PWR_SHIFT);
            if (sh > 64'h0000_0000_FFFF_FFFF) begin
              e.pwr[k] = 32'hFFFF_FFFF; ns++;
            end else begin
              e.pwr[k] = sh[31:0];
            end
            m_acc[k] = 0;
          end
          m_sat = (m_sat + ns > 65535) ? 65535 : m_sat + ns;
          e.sat = 16'(m_sat);
          m_cnt = 0;
          m_rbg = (m_rbg + 1) % 16;
          if (eop) m_in_pkt = 1'b0;
        end
      end
    end
    exp_q[n + 3] = e;
  endtask

  task automatic step(input logic rst, vld, sop, eop, input logic [15:0][31:0] d);
    i_reset = rst; i_vld = vld; i_sop = sop; i_eop = eop; i_ant_data = d;
    model_apply(pe_cnt + 1, rst, vld, sop, eop, d);
    @(negedge clk);
  endtask

  function automatic logic [15:0][31:0] rand_data();
    logic [15:0][31:0] d;
    int r;
    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) d[k] = 32'h8000_8000;
      else if (r == 1) d[k] = 32'h7FFF_8001;
      else d[k] = $urandom;
    end
    return d;
  endfunction

  function automatic logic [15:0][31:0] fill(input logic [31:0] w);
    logic [15:0][31:0] d;
    for (int k = 0; k < 16; k++) d[k] = w;
    return d;
  endfunction

  task automatic send_pkt(input int len, input logic [15:0][31:0] d, input int gap_mode);
    for (int r = 0; r < len; r++) begin
      if (gap_mode == 1 && r > 0) step(1'b0, 1'b0, 1'b0, 1'b0, rand_data());
      step(1'b0, 1'b1, r == 0, r == len - 1, d);
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, 1'b0, rand_data());
  endtask

  // Every-cycle comparison of the DUT against the model's expected outputs
  exp_t              ce;
  logic [15:0][31:0] h_pwr;
  logic [3:0]        h_idx;
  logic [15:0]       h_sat;
  always @(posedge clk) begin
    pe_cnt = pe_cnt + 1;
    #1;
    ce = exp_q[pe_cnt];
    if (ce.rst) begin
      h_pwr = '0; h_idx = 4'd0; h_sat = 16'd0;
    end else if (ce.load) begin
      h_pwr = ce.pwr; h_idx = ce.idx; h_sat = ce.sat;
    end
    chk("o_vld", 512'(o_vld), 512'(ce.vld));
    chk("o_sop", 512'(o_sop), 512'(ce.sop));
    chk("o_eop", 512'(o_eop), 512'(ce.eop));
    chk("o_ant_data", o_ant_data, ce.data);
    chk("o_rbg_load", 512'(o_rbg_load), 512'(ce.load));
    chk("o_ant_pwr", o_ant_pwr, h_pwr);
    chk("o_rbg_idx", 512'(o_rbg_idx), 512'(h_idx));
`ifdef PWR_SAT_CNT_EN
    chk("o_sat_cnt", 512'(o_sat_cnt), 512'(h_sat));
`endif
    if (o_rbg_load === 1'b1) load_seen++;
  end

  int                lc;
  logic [15:0][31:0] d2, dexp;
  initial begin
    for (int j = 0; j < NCYC; j++) exp_q[j] = zero_exp();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("reset_pwr", o_ant_pwr, '0);

    // 1: 48 REs I=100,Q=0
    lc = load_seen;
    send_pkt(RBG_RE, fill({16'd100, 16'd0}), 0);
    idle(6);
    chk("t1_loads", 512'(load_seen - lc), 512'(1));
    chk("t1_pwr", o_ant_pwr, fill(32'd480000));
    chk("t1_idx", 512'(o_rbg_idx), 512'(0));

    // 2: 96 REs, antenna k carries I=Q=k
    for (int k = 0; k < 16; k++) d2[k] = {16'(k), 16'(k)};
    for (int k = 0; k < 16; k++) dexp[k] = 32'(96 * k * k);
    lc = load_seen;
    send_pkt(2 * RBG_RE, d2, 0);
    idle(6);
    chk("t2_loads", 512'(load_seen - lc), 512'(2));
    chk("t2_pwr", o_ant_pwr, dexp);
    chk("t2_idx", 512'(o_rbg_idx), 512'(1));

    // 3: saturating 20-RE partial RBG right after reset
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    send_pkt(20, fill(32'h8000_8000), 0);
    idle(6);
    chk("t3_pwr", o_ant_pwr, fill(32'hFFFF_FFFF));
    chk("t3_idx", 512'(o_rbg_idx), 512'(0));
`ifdef PWR_SAT_CNT_EN
    chk("t3_sat_cnt", 512'(o_sat_cnt), 512'(16));
`endif

    // 4: test 1 with vld low every other cycle
    lc = load_seen;
    send_pkt(RBG_RE, fill({16'd100, 16'd0}), 1);
    idle(6);
    chk("t4_loads", 512'(load_seen - lc), 512'(1));
    chk("t4_pwr", o_ant_pwr, fill(32'd480000));

    // 5: restart by sop without eop, then reset mid-packet
    lc = load_seen;
    for (int r = 0; r < 30; r++) step(1'b0, 1'b1, r == 0, 1'b0, fill({16'd50, 16'd7}));
    send_pkt(RBG_RE, fill({16'd0, 16'hFF9C}), 0);
    idle(6);
    chk("t5_loads", 512'(load_seen - lc), 512'(1));
    chk("t5_pwr", o_ant_pwr, fill(32'd480000));
    chk("t5_idx", 512'(o_rbg_idx), 512'(0));
    lc = load_seen;
    for (int r = 0; r < 10; r++) step(1'b0, 1'b1, r == 0, 1'b0, rand_data());
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("t5_rst_pwr", o_ant_pwr, '0);
    idle(8);
    chk("t5_rst_loads", 512'(load_seen - lc), 512'(0));

    // 6: 17 RBGs in one packet, then sop-less traffic
    lc = load_seen;
    for (int r = 0; r < 17 * RBG_RE; r++)
      step(1'b0, 1'b1, r == 0, r == 17 * RBG_RE - 1, rand_data());
    idle(6);
    chk("t6_loads", 512'(load_seen - lc), 512'(17));
    chk("t6_idx", 512'(o_rbg_idx), 512'(0));
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    lc = load_seen;
    for (int r = 0; r < 20; r++) step(1'b0, 1'b1, 1'b0, r == 19, rand_data());
    idle(6);
    chk("t6_nosop_loads", 512'(load_seen - lc), 512'(0));

    // Randomized packets: gaps, early restarts, resets, back-to-back
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 120);
      for (int r = 0; r < len; r++) begin
        if ($urandom_range(0, 199) == 0) step(1'b1, 1'b0, 1'b0, 1'b0, rand_data());
        while ($urandom_range(0, 4) == 0) step(1'b0, 1'b0, $urandom_range(0, 1) == 1, 1'b0, rand_data());
        step(1'b0, 1'b1, (r == 0) || ($urandom_range(0, 99) < 2), r == len - 1, rand_data());
      end
      idle($urandom_range(0, 3));
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
